// File: rtl/seq_table_loader_pkg.sv
// Shared constants, state encodings and the commit rule for the sequencer table loader.
// Imported by the line RAM and the loader top.
package seq_table_loader_pkg;

  localparam int LINE_WORDS = 4;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = LINE_WORDS * WORD_W;
  localparam int PART_W     = (LINE_WORDS - 1) * WORD_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

  // A table commits only as a non-empty whole number of lines that matches what arrived.
  function automatic logic commit_ok(input logic [15:0] len,
                                     input logic [15:0] words,
                                     input int unsigned depth);
    logic [31:0] len_lines;
    len_lines = {18'd0, len[15:2]};
    return (len != 16'd0) && (len[1:0] == 2'b00) && (len == words) && (len_lines <= depth);
  endfunction

endpackage

// File: rtl/seq_table_loader_if.sv
// Register-write side and sequencer read/status side of the table loader.
// All *_WSTB inputs are single-cycle event strobes: each high cycle is one write, there is
// no ready/backpressure, and a strobe seen outside a state that accepts it is dropped.
interface seq_table_loader_if #(
  parameter int AW = 9
);
  logic          TABLE_START;
  logic          TABLE_START_WSTB;
  logic [31:0]   TABLE_DATA;
  logic          TABLE_WSTB;
  logic [15:0]   TABLE_LENGTH;
  logic          TABLE_LENGTH_WSTB;
  logic [AW-1:0] rd_addr_i;
  logic [127:0]  rd_data_o;
  logic          table_valid_o;
  logic [AW:0]   table_lines_o;
  logic [15:0]   words_o;
  logic          load_err_o;
  logic [1:0]    state_o;

  modport master (
    output TABLE_START, TABLE_START_WSTB, TABLE_DATA, TABLE_WSTB,
           TABLE_LENGTH, TABLE_LENGTH_WSTB, rd_addr_i,
    input  rd_data_o, table_valid_o, table_lines_o, words_o, load_err_o, state_o
  );

  modport slave (
    input  TABLE_START, TABLE_START_WSTB, TABLE_DATA, TABLE_WSTB,
           TABLE_LENGTH, TABLE_LENGTH_WSTB, rd_addr_i,
    output rd_data_o, table_valid_o, table_lines_o, words_o, load_err_o, state_o
  );
endinterface

// File: rtl/seq_table_loader_line_ram.sv
// Simple dual-port line RAM: synchronous write, registered read with read-old-data on a
// same-address collision. Contents are never cleared; only the read register resets.
module seq_table_loader_line_ram
  import seq_table_loader_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [LINE_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [LINE_W-1:0] rd_data_o
);

  logic [LINE_W-1:0] mem [DEPTH];
  logic [LINE_W-1:0] rd_data_q;
  logic [LINE_W-1:0] rd_data_d;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Sampled before this edge's write lands, so a colliding read sees the previous line.
  always_comb begin
    rd_data_d = mem[rd_addr_i];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/seq_table_loader.sv
// Packs 32-bit table words into 128-bit lines in line RAM and commits a complete table
// for the sequencer; reports load progress, a sticky error and the FSM state.
module seq_table_loader
  import seq_table_loader_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic               clk_i,
  input  logic               reset_i,
  seq_table_loader_if.slave  bus
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [1:0]        state_q,   state_d;
  logic [15:0]       words_q,   words_d;
  logic [AW:0]       wr_line_q, wr_line_d;
  logic [PART_W-1:0] part_q,    part_d;
  logic              valid_q,   valid_d;
  logic              err_q,     err_d;
  logic [AW:0]       lines_q,   lines_d;

  logic              ram_we;
  logic [LINE_W-1:0] ram_wdata;
  logic [15:0]       words_eff;
  logic              overflow;
  logic              unused_table_start;

  // The register value of TABLE_START carries no meaning; only its strobe does.
  assign unused_table_start = bus.TABLE_START;

  always_comb begin
    state_d   = state_q;
    words_d   = words_q;
    wr_line_d = wr_line_q;
    part_d    = part_q;
    valid_d   = valid_q;
    err_d     = err_q;
    lines_d   = lines_q;
    ram_we    = 1'b0;
    ram_wdata = {bus.TABLE_DATA, part_q};
    words_eff = words_q;
    overflow  = 1'b0;

    if (bus.TABLE_START_WSTB) begin
      state_d   = ST_LOADING;
      words_d   = '0;
      wr_line_d = '0;
      part_d    = '0;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      lines_d   = '0;
    end else if (state_q == ST_LOADING) begin
      if (bus.TABLE_WSTB) begin
        if (wr_line_q == DEPTH_L) begin
          overflow = 1'b1;
        end else begin
          case (words_q[1:0])
            2'd0:    part_d[31:0]  = bus.TABLE_DATA;
            2'd1:    part_d[63:32] = bus.TABLE_DATA;
            2'd2:    part_d[95:64] = bus.TABLE_DATA;
            default: begin
              ram_we    = 1'b1;
              wr_line_d = wr_line_q + 1'b1;
            end
          endcase
          words_eff = words_q + 16'd1;
        end
      end
      words_d = words_eff;

      // A same-cycle length write is judged against the count including this word.
      if (overflow) begin
        state_d = ST_ERROR;
        err_d   = 1'b1;
        valid_d = 1'b0;
      end else if (bus.TABLE_LENGTH_WSTB) begin
        if (commit_ok(bus.TABLE_LENGTH, words_eff, DEPTH)) begin
          state_d = ST_READY;
          valid_d = 1'b1;
          lines_d = bus.TABLE_LENGTH[AW+2:2];
        end else begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      words_q   <= '0;
      wr_line_q <= '0;
      part_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      lines_q   <= '0;
    end else begin
      state_q   <= state_d;
      words_q   <= words_d;
      wr_line_q <= wr_line_d;
      part_q    <= part_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      lines_q   <= lines_d;
    end
  end

  seq_table_loader_line_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_line_ram (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .we_i      (ram_we),
    .wr_addr_i (wr_line_q[AW-1:0]),
    .wr_data_i (ram_wdata),
    .rd_addr_i (bus.rd_addr_i),
    .rd_data_o (bus.rd_data_o)
  );

  assign bus.table_valid_o = valid_q;
  assign bus.table_lines_o = lines_q;
  assign bus.words_o       = words_q;
  assign bus.load_err_o    = err_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_seq_table_loader.sv
// Directed bench for seq_table_loader: hand-computed expectations checked with immediate
// assertions after each step.
module tb_seq_table_loader;

  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic clk_i;
  logic reset_i;
  int   n_vec;
  int   n_err;

  seq_table_loader_if #(.AW(AW)) bus ();

  seq_table_loader #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.TABLE_START       = 1'b0;
    bus.TABLE_START_WSTB  = 1'b0;
    bus.TABLE_DATA        = '0;
    bus.TABLE_WSTB        = 1'b0;
    bus.TABLE_LENGTH      = '0;
    bus.TABLE_LENGTH_WSTB = 1'b0;
  endtask

  task automatic do_start();
    bus.TABLE_START_WSTB = 1'b1;
    tick();
    bus.TABLE_START_WSTB = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] data);
    bus.TABLE_DATA = data;
    bus.TABLE_WSTB = 1'b1;
    tick();
    bus.TABLE_WSTB = 1'b0;
  endtask

  task automatic commit(input logic [15:0] len);
    bus.TABLE_LENGTH      = len;
    bus.TABLE_LENGTH_WSTB = 1'b1;
    tick();
    bus.TABLE_LENGTH_WSTB = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic [1:0] st, input logic valid,
                              input logic err, input logic [AW:0] lines, input logic [15:0] words);
    check({tag, ".state"}, 128'(bus.state_o), 128'(st));
    check({tag, ".valid"}, 128'(bus.table_valid_o), 128'(valid));
    check({tag, ".err"},   128'(bus.load_err_o), 128'(err));
    check({tag, ".lines"}, 128'(bus.table_lines_o), 128'(lines));
    check({tag, ".words"}, 128'(bus.words_o), 128'(words));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    bus.rd_addr_i = '0;

    // Reset state
    reset_i = 1'b1;
    #12;
    check_status("reset", 2'd0, 1'b0, 1'b0, '0, 16'd0);
    check("reset.rd_data", bus.rd_data_o, 128'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    tick();

    // Ignored strobes in IDLE
    write_word(32'h55);
    commit(16'd4);
    check_status("idle_ignore", 2'd0, 1'b0, 1'b0, '0, 16'd0);

    // 1: eight words 1..8, commit 8
    do_start();
    check_status("t1_start", 2'd1, 1'b0, 1'b0, '0, 16'd0);
    for (int i = 1; i <= 8; i++) write_word(32'(i));
    check_status("t1_loaded", 2'd1, 1'b0, 1'b0, '0, 16'd8);
    commit(16'd8);
    check_status("t1_commit", 2'd2, 1'b1, 1'b0, 10'd2, 16'd8);
    bus.rd_addr_i = 9'd1;
    tick();
    check("t1_rd1", bus.rd_data_o, {32'd8, 32'd7, 32'd6, 32'd5});
    bus.rd_addr_i = 9'd0;
    tick();
    check("t1_rd0", bus.rd_data_o, {32'd4, 32'd3, 32'd2, 32'd1});
    write_word(32'h99);
    check_status("ready_ignore", 2'd2, 1'b1, 1'b0, 10'd2, 16'd8);

    // Collision: line 0 rewritten while being read returns the old line, then the new one
    do_start();
    write_word(32'hA0);
    write_word(32'hA1);
    write_word(32'hA2);
    write_word(32'hA3);
    check("coll_old", bus.rd_data_o, {32'd4, 32'd3, 32'd2, 32'd1});
    tick();
    check("coll_new", bus.rd_data_o, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    // 2: six words, length 6 -> error; restart clears it
    do_start();
    for (int i = 0; i < 6; i++) write_word(32'(i + 16));
    commit(16'd6);
    check_status("t2_err", 2'd3, 1'b0, 1'b1, '0, 16'd6);
    write_word(32'h77);
    commit(16'd8);
    check_status("t2_err_ignore", 2'd3, 1'b0, 1'b1, '0, 16'd6);
    do_start();
    check_status("t2_restart", 2'd1, 1'b0, 1'b0, '0, 16'd0);

    // 3: length mismatch, then zero length on a fresh load
    for (int i = 0; i < 8; i++) write_word(32'(i));
    commit(16'd12);
    check_status("t3_mismatch", 2'd3, 1'b0, 1'b1, '0, 16'd8);
    do_start();
    commit(16'd0);
    check_status("t3_zero", 2'd3, 1'b0, 1'b1, '0, 16'd0);

    // Same-cycle final word and length write count the word
    do_start();
    for (int i = 0; i < 7; i++) write_word(32'(i));
    bus.TABLE_DATA        = 32'd7;
    bus.TABLE_WSTB        = 1'b1;
    bus.TABLE_LENGTH      = 16'd8;
    bus.TABLE_LENGTH_WSTB = 1'b1;
    tick();
    idle_inputs();
    check_status("same_cycle_commit", 2'd2, 1'b1, 1'b0, 10'd2, 16'd8);

    // 4: fill all DEPTH lines, then one extra word overflows
    do_start();
    for (int i = 0; i < DEPTH * 4; i++) write_word(32'(i));
    check_status("t4_full", 2'd1, 1'b0, 1'b0, '0, 16'd2048);
    write_word(32'hDEAD);
    check_status("t4_overflow", 2'd3, 1'b0, 1'b1, '0, 16'd2048);
    bus.rd_addr_i = 9'd511;
    tick();
    check("t4_last_line", bus.rd_data_o, {32'd2047, 32'd2046, 32'd2045, 32'd2044});
    bus.rd_addr_i = 9'd0;

    // 5: READY with 2 lines, then START and TABLE_WSTB together
    do_start();
    for (int i = 1; i <= 8; i++) write_word(32'(i));
    commit(16'd8);
    check_status("t5_ready", 2'd2, 1'b1, 1'b0, 10'd2, 16'd8);
    bus.TABLE_START_WSTB = 1'b1;
    bus.TABLE_DATA       = 32'h1234;
    bus.TABLE_WSTB       = 1'b1;
    tick();
    idle_inputs();
    check_status("t5_start_wins", 2'd1, 1'b0, 1'b0, '0, 16'd0);

    // 6: reset mid-load after three words
    for (int i = 0; i < 3; i++) write_word(32'(i));
    check_status("t6_partial", 2'd1, 1'b0, 1'b0, '0, 16'd3);
    #2;
    reset_i = 1'b1;
    #1;
    check_status("t6_async_reset", 2'd0, 1'b0, 1'b0, '0, 16'd0);
    tick();
    reset_i = 1'b0;
    write_word(32'h42);
    write_word(32'h43);
    check_status("t6_ignore", 2'd0, 1'b0, 1'b0, '0, 16'd0);
    do_start();
    check_status("t6_restart", 2'd1, 1'b0, 1'b0, '0, 16'd0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
